// File: rtl/exc_ctrl_if.sv
// Bundle of MEM-stage exception inputs, CP0 state and the flush/redirect outputs.
interface exc_ctrl_if;
   logic        syscall_i;
   logic        inst_invalid_i;
   logic        trap_i;
   logic        ov_i;
   logic        eret_i;
   logic        inst_valid_i;
   logic [31:0] pc_i;
   logic        in_delayslot_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   // Controller side
   modport slave (
      input  syscall_i, inst_invalid_i, trap_i, ov_i, eret_i, inst_valid_i,
      input  pc_i, in_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
      input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      output excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, new_pc_o
   );

   // Pipeline / stimulus side
   modport master (
      output syscall_i, inst_invalid_i, trap_i, ov_i, eret_i, inst_valid_i,
      output pc_i, in_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
      output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
      input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, new_pc_o
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception controller: detects MEM-stage exceptions/interrupts, then issues a
// one-cycle flush with the exception code, faulting PC and redirect target.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | watching MEM stage; outputs zero
// ST_FLUSH | one-cycle flush in progress; inputs ignored, outputs valid
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
   input logic       clk,
   input logic       rst,
   exc_ctrl_if.slave bus
);

   typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

   localparam logic [31:0] CODE_INT   = 32'h1;
   localparam logic [31:0] CODE_SYS   = 32'h8;
   localparam logic [31:0] CODE_INV   = 32'ha;
   localparam logic [31:0] CODE_TRAP  = 32'hd;
   localparam logic [31:0] CODE_OV    = 32'hc;
   localparam logic [31:0] CODE_ERET  = 32'he;

   state_t      state_q, state_d;
   logic [31:0] excepttype_q, excepttype_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic        delayslot_q, delayslot_d;
   logic [31:0] new_pc_q, new_pc_d;

   logic [31:0] eff_status;
   logic [7:0]  eff_cause_ip;
   logic [31:0] eff_epc;
   logic        int_pending;
   logic [31:0] code;
   logic        unused_bits;

   // Forward an in-flight mtc0 so detection sees the CP0 value it is about to hold
   always_comb begin
      eff_status   = bus.cp0_status_i;
      eff_cause_ip = bus.cp0_cause_i[15:8];
      eff_epc      = bus.cp0_epc_i;
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) eff_status = bus.wb_cp0_data_i;
      // only the software interrupt bits of cause are writable
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) eff_cause_ip[1:0] = bus.wb_cp0_data_i[9:8];
      if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) eff_epc = bus.wb_cp0_data_i;
   end

   assign int_pending = eff_status[0] && !eff_status[1] &&
                        ((eff_cause_ip & eff_status[15:8]) != 8'd0);

   assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                          bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0]};

   // Priority encode the pending exception; zero means nothing to take
   always_comb begin
      code = 32'h0;
      if      (int_pending)        code = CODE_INT;
      else if (bus.syscall_i)      code = CODE_SYS;
      else if (bus.inst_invalid_i) code = CODE_INV;
      else if (bus.trap_i)         code = CODE_TRAP;
      else if (bus.ov_i)           code = CODE_OV;
      else if (bus.eret_i)         code = CODE_ERET;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         excepttype_q <= 32'h0;
         inst_addr_q  <= 32'h0;
         delayslot_q  <= 1'b0;
         new_pc_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         excepttype_q <= excepttype_d;
         inst_addr_q  <= inst_addr_d;
         delayslot_q  <= delayslot_d;
         new_pc_q     <= new_pc_d;
      end
   end

   // Next state; captured values are cleared whenever we are not entering FLUSH
   always_comb begin
      state_d      = ST_IDLE;
      excepttype_d = 32'h0;
      inst_addr_d  = 32'h0;
      delayslot_d  = 1'b0;
      new_pc_d     = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (bus.inst_valid_i && code != 32'h0) begin
               state_d      = ST_FLUSH;
               excepttype_d = code;
               inst_addr_d  = bus.pc_i;
               delayslot_d  = bus.in_delayslot_i;
               new_pc_d     = (code == CODE_ERET) ? eff_epc : EXC_VECTOR;
            end
         end
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Drive the CP0 / pipeline outputs from the registered state
   always_comb begin
      bus.flush_o             = (state_q == ST_FLUSH);
      bus.excepttype_o        = excepttype_q;
      bus.current_inst_addr_o = inst_addr_q;
      bus.is_in_delayslot_o   = delayslot_q;
      bus.new_pc_o            = new_pc_q;
   end

endmodule
